// File: rtl/lock_prog.sv
// lock_prog: four-digit combination lock with a programmable code,
// consecutive-failure lockout and a thermometer display of entry progress.
// ostate encodes the state directly (00 LOCKED, 01 OPEN, 10 PROG, 11 LOCKOUT).
module lock_prog #(
  parameter logic [15:0] DEFAULT_CODE   = 16'hA5C3,
  parameter int unsigned LOCKOUT_CYCLES = 100_000_000,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic [3:0] isw,
  input  logic       ibtn,
  input  logic       iprog,
  output logic [3:0] oled,
  output logic [1:0] ostate
);

  // Timer counts LOCKOUT_CYCLES-1 down to 0, so it never needs to hold LOCKOUT_CYCLES itself.
  localparam int                TW         = $clog2(LOCKOUT_CYCLES);
  localparam logic [TW-1:0]     TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]        FAIL_LIMIT = 2'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'b00,
    ST_OPEN    = 2'b01,
    ST_PROG    = 2'b10,
    ST_LOCKOUT = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  // Only the first three digits are buffered: the fourth is always taken
  // straight from isw on the edge that completes the entry.
  logic [11:0]   buf_q, buf_d;
  logic [1:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   code_q, code_d;
  logic [3:0]    oled_q, oled_d;

  // Edge history. The *_mask_q flags remember a button that was high on the
  // reset edge, so a button held through reset is not seen as a fresh press
  // even though the history registers themselves are cleared by reset.
  logic          btn_prev_q, prog_prev_q;
  logic          btn_mask_q, prog_mask_q;

  logic          btn_press, prog_press;
  logic          last_digit;
  logic [15:0]   entered;
  logic [1:0]    fail_inc;

  assign btn_press  = ibtn  & ~btn_prev_q  & ~btn_mask_q;
  assign prog_press = iprog & ~prog_prev_q & ~prog_mask_q;
  assign last_digit = (cnt_q == 3'd3);
  assign entered    = {buf_q, isw};
  assign fail_inc   = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;

  // Next-state logic for the lock FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    code_d  = code_q;

    unique case (state_q)
      ST_LOCKED: begin
        if (btn_press) begin
          if (last_digit) begin
            cnt_d = 3'd0;
            buf_d = 12'd0;
            if (entered == code_q) begin
              state_d = ST_OPEN;
              fail_d  = 2'd0;
            end else begin
              fail_d = fail_inc;
              if (fail_inc >= FAIL_LIMIT) begin
                state_d = ST_LOCKOUT;
                timer_d = TIMER_LOAD;
              end
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            buf_d = {buf_q[7:0], isw};
          end
        end
      end

      ST_OPEN: begin
        cnt_d = 3'd0;
        buf_d = 12'd0;
        // Lock request wins when both buttons fire on the same edge.
        if (btn_press) begin
          state_d = ST_LOCKED;
        end else if (prog_press) begin
          state_d = ST_PROG;
        end
      end

      ST_PROG: begin
        // Abort wins over a simultaneous digit; the digit is dropped.
        if (prog_press) begin
          state_d = ST_OPEN;
          cnt_d   = 3'd0;
          buf_d   = 12'd0;
        end else if (btn_press) begin
          if (last_digit) begin
            code_d  = entered;
            state_d = ST_OPEN;
            cnt_d   = 3'd0;
            buf_d   = 12'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
            buf_d = {buf_q[7:0], isw};
          end
        end
      end

      ST_LOCKOUT: begin
        cnt_d = 3'd0;
        buf_d = 12'd0;
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
          fail_d  = 2'd0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d = ST_LOCKED;
        cnt_d   = 3'd0;
        buf_d   = 12'd0;
      end
    endcase
  end

  // LED pattern for the state being entered, so oled is registered alongside it.
  always_comb begin
    oled_d = 4'b0000;
    unique case (state_d)
      ST_OPEN:    oled_d = 4'b1111;
      ST_LOCKOUT: oled_d = 4'b1001;
      default:    oled_d = {1'b0, cnt_d >= 3'd3, cnt_d >= 3'd2, cnt_d >= 3'd1};
    endcase
  end

  // State, datapath and edge-history registers with synchronous reset.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= ST_LOCKED;
      cnt_q       <= 3'd0;
      buf_q       <= 12'd0;
      fail_q      <= 2'd0;
      timer_q     <= '0;
      code_q      <= DEFAULT_CODE;
      oled_q      <= 4'b0000;
      btn_prev_q  <= 1'b0;
      prog_prev_q <= 1'b0;
      btn_mask_q  <= ibtn;
      prog_mask_q <= iprog;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      code_q      <= code_d;
      oled_q      <= oled_d;
      btn_prev_q  <= ibtn;
      prog_prev_q <= iprog;
      btn_mask_q  <= 1'b0;
      prog_mask_q <= 1'b0;
    end
  end

  assign ostate = state_q;
  assign oled   = oled_q;

endmodule
